multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have no parameters; all encodings below are fixed.
REQ-002 SHALL have port `clk`: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port `reset`: input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port `OpCode`: input, 6 bits, IR[31:26], held stable by the datapath from IRWrite until the next IRWrite.
REQ-005 SHALL have port `Funct`: input, 6 bits, IR[5:0].
REQ-006 SHALL have port `mem_ack`: input, 1 bit, memory completion strobe, sampled only while mem_req=1.
REQ-007 SHALL have ports `mem_req`, `MemRead`, `MemWrite`: outputs, 1 bit each; `IorD`: output, 1 bit, 0=PC address, 1=ALUOut address.
REQ-008 SHALL have ports `IRWrite`, `PCWrite`, `PCWriteCond`, `RegWrite`: outputs, 1 bit each.
REQ-009 SHALL have port `ALUSrcA`: output, 1 bit, 0=PC, 1=rs; `ALUSrcB`: output, 2 bits, 0=rt, 1=const 4, 2=sign/zero-ext imm, 3=imm<<2.
REQ-010 SHALL have port `ALUOpSel`: output, 2 bits, 0=force add, 1=force subtract, 2=use OpCode/Funct decode.
REQ-011 SHALL have port `PCSource`: output, 2 bits, 0=ALU result, 1=ALUOut, 2=jump target, 3=rs.
REQ-012 SHALL have ports `RegDst`: output, 2 bits, 0=rt, 1=rd, 2=$31; `MemtoReg`: output, 2 bits, 0=ALUOut, 1=MDR, 2=PC.
REQ-013 SHALL have port `state`: output, 3 bits, current FSM state; `trap`: output, 1 bit, illegal-instruction flag.
REQ-014 SHALL have port `instr_done`: output, 1 bit, one-cycle retire pulse; `retired`: output, 32 bits, retired-instruction count.

Function
REQ-015 SHALL implement states IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=5; codes 6 and 7 SHALL go to TRAP.
REQ-016 SHALL drive outputs as Moore/Mealy decodes of state, OpCode, Funct and mem_ack; every output not listed for a state SHALL be 0.
REQ-017 IF: mem_req=1, MemRead=1, IorD=0; SHALL stay in IF until mem_ack=1.
REQ-018 IF, in the mem_ack cycle: IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=1, ALUOpSel=0, PCSource=0; SHALL then go to ID.
REQ-019 ID: ALUSrcA=0, ALUSrcB=3, ALUOpSel=0 (branch target to ALUOut).
REQ-020 Legal OpCodes SHALL be 0x23, 0x2B, 0x0F, 0x08, 0x09, 0x0C, 0x0A, 0x0B, 0x04, 0x02, 0x03, plus 0x00 with Funct in {0x20-0x27, 0x2A, 0x2B, 0x00, 0x02, 0x03, 0x08, 0x09}.
REQ-021 ID: any other OpCode/Funct SHALL go to TRAP with no write strobe asserted.
REQ-022 ID, j: PCWrite=1, PCSource=2, then go to IF.
REQ-023 ID, jal: as j, plus RegWrite=1, RegDst=2, MemtoReg=2, then go to IF.
REQ-024 ID, jr: PCWrite=1, PCSource=3, then go to IF.
REQ-025 ID, jalr: as jr, plus RegWrite=1, RegDst=1, MemtoReg=2, then go to IF.
REQ-026 ID: all other legal instructions SHALL go to EX.
REQ-027 EX, lw/sw: ALUSrcA=1, ALUSrcB=2, ALUOpSel=0; SHALL then go to MEM.
REQ-028 EX, beq: ALUSrcA=1, ALUSrcB=0, ALUOpSel=1, PCWriteCond=1, PCSource=1; SHALL then go to IF.
REQ-029 EX, R-type ALU ops: ALUSrcA=1, ALUSrcB=0, ALUOpSel=2; SHALL then go to WB.
REQ-030 EX, I-type ALU ops and lui: ALUSrcA=1, ALUSrcB=2, ALUOpSel=2; SHALL then go to WB.
REQ-031 MEM: mem_req=1, IorD=1, MemRead=1 for lw, MemWrite=1 for sw; SHALL hold until mem_ack=1.
REQ-032 MEM, on mem_ack: sw SHALL go to IF; lw SHALL go to WB.
REQ-033 WB: RegWrite=1 for exactly one cycle, then go to IF.
REQ-034 WB: RegDst=1 for R-type, else 0; MemtoReg=1 for lw, else 0.
REQ-035 instr_done SHALL pulse in the last cycle of each instruction (the state whose next state is IF); retired SHALL increment on that same edge.
REQ-036 retired SHALL wrap from 0xFFFFFFFF to 0.
REQ-037 TRAP: trap=1 and all strobes 0; SHALL be held until reset.
REQ-038 mem_ack while mem_req=0 SHALL be ignored; mem_req SHALL never deassert before its ack.

Reset
REQ-039 reset=0 SHALL asynchronously force state=IF, trap=0, retired=0.
REQ-040 SHALL force all strobes to 0 while reset=0, including an abort mid-MEM or mid-IF.
REQ-041 The first cycle after reset release SHALL be IF with mem_req=1.

Verification
REQ-042 add (OpCode 0x00, Funct 0x20), ack latency 2 -> IF for 3 cycles, then ID, EX (ALUOpSel=2), WB (RegWrite=1, RegDst=1), instr_done=1, retired=1.
REQ-043 lw (0x23), MEM ack latency 0 -> states IF, ID, EX, MEM, WB; MemtoReg=1 in WB; 5 cycles total.
REQ-044 sw (0x2B) -> MemWrite=1 only in MEM; RegWrite never 1; returns to IF after ack.
REQ-045 jal (0x03) -> retires in ID with PCWrite=1, PCSource=2, RegWrite=1, RegDst=2; retired counter preloaded to 0xFFFFFFFF wraps to 0.
REQ-046 OpCode 0x3F -> TRAP after ID with trap=1 and no strobes; stays in TRAP for 100 cycles; reset pulse returns to IF.
REQ-047 reset=0 asserted in MEM with mem_req=1 -> mem_req=0 in the same cycle; after release, state=IF, retired=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control unit: IF/ID/EX/MEM/WB sequencer with a memory handshake,
// illegal-instruction trap and a free-running retired-instruction counter.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  OpCode,
  input  logic [5:0]  Funct,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOpSel,
  output logic [1:0]  PCSource,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [2:0]  state,
  output logic        trap,
  output logic        instr_done,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    StIf   = 3'd0,
    StId   = 3'd1,
    StEx   = 3'd2,
    StMem  = 3'd3,
    StWb   = 3'd4,
    StTrap = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] retired_q;

  logic is_r, is_lw, is_sw, is_beq, is_j, is_jal, is_jr, is_jalr, is_ralu, is_ialu, legal;

  always_comb begin
    is_r    = (OpCode == 6'h00);
    is_lw   = (OpCode == 6'h23);
    is_sw   = (OpCode == 6'h2B);
    is_beq  = (OpCode == 6'h04);
    is_j    = (OpCode == 6'h02);
    is_jal  = (OpCode == 6'h03);
    is_jr   = is_r && (Funct == 6'h08);
    is_jalr = is_r && (Funct == 6'h09);
    is_ralu = is_r && (Funct inside {[6'h20:6'h27], 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03});
    is_ialu = OpCode inside {6'h08, 6'h09, 6'h0C, 6'h0A, 6'h0B, 6'h0F};
    legal   = is_lw | is_sw | is_beq | is_j | is_jal | is_jr | is_jalr | is_ralu | is_ialu;
  end

  // Outputs are decoded combinationally and gated by reset so an abort drops every strobe
  // in the same cycle, not at the next edge.
  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'd0;
    ALUOpSel    = 2'd0;
    PCSource    = 2'd0;
    RegDst      = 2'd0;
    MemtoReg    = 2'd0;
    trap        = 1'b0;
    instr_done  = 1'b0;
    if (reset) begin
      case (state_q)
        StIf: begin
          mem_req = 1'b1;
          MemRead = 1'b1;
          if (mem_ack) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            ALUSrcB = 2'd1;
            state_d = StId;
          end
        end
        StId: begin
          ALUSrcB = 2'd3;
          if (!legal) begin
            state_d = StTrap;
          end else if (is_j || is_jal) begin
            PCWrite    = 1'b1;
            PCSource   = 2'd2;
            instr_done = 1'b1;
            state_d    = StIf;
            if (is_jal) begin
              RegWrite = 1'b1;
              RegDst   = 2'd2;
              MemtoReg = 2'd2;
            end
          end else if (is_jr || is_jalr) begin
            PCWrite    = 1'b1;
            PCSource   = 2'd3;
            instr_done = 1'b1;
            state_d    = StIf;
            if (is_jalr) begin
              RegWrite = 1'b1;
              RegDst   = 2'd1;
              MemtoReg = 2'd2;
            end
          end else begin
            state_d = StEx;
          end
        end
        StEx: begin
          ALUSrcA = 1'b1;
          if (is_lw || is_sw) begin
            ALUSrcB = 2'd2;
            state_d = StMem;
          end else if (is_beq) begin
            ALUOpSel    = 2'd1;
            PCWriteCond = 1'b1;
            PCSource    = 2'd1;
            instr_done  = 1'b1;
            state_d     = StIf;
          end else if (is_ralu) begin
            ALUOpSel = 2'd2;
            state_d  = StWb;
          end else if (is_ialu) begin
            ALUSrcB  = 2'd2;
            ALUOpSel = 2'd2;
            state_d  = StWb;
          end else begin
            state_d = StTrap;
          end
        end
        StMem: begin
          mem_req  = 1'b1;
          IorD     = 1'b1;
          MemRead  = is_lw;
          MemWrite = is_sw;
          if (mem_ack) begin
            if (is_lw) begin
              state_d = StWb;
            end else begin
              instr_done = 1'b1;
              state_d    = StIf;
            end
          end
        end
        StWb: begin
          RegWrite   = 1'b1;
          RegDst     = is_r ? 2'd1 : 2'd0;
          MemtoReg   = is_lw ? 2'd1 : 2'd0;
          instr_done = 1'b1;
          state_d    = StIf;
        end
        StTrap: begin
          trap = 1'b1;
        end
        default: begin
          state_d = StTrap;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIf;
      retired_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (instr_done) begin
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-instruction phase model queues the expected output
// vector for every cycle and a single negedge process compares it against the DUT.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  OpCode, Funct;
  logic        mem_ack;
  logic        mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, RegWrite;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOpSel, PCSource, RegDst, MemtoReg;
  logic [2:0]  state;
  logic        trap, instr_done;
  logic [31:0] retired;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .mem_ack(mem_ack),
    .mem_req(mem_req), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOpSel(ALUOpSel), .PCSource(PCSource),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .state(state), .trap(trap),
    .instr_done(instr_done), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, RegWrite;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOpSel, PCSource, RegDst, MemtoReg;
    logic [2:0]  state;
    logic        trap, instr_done;
    logic [31:0] retired;
  } outs_t;

  outs_t act;
  always_comb act = {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, RegWrite,
                     ALUSrcA, ALUSrcB, ALUOpSel, PCSource, RegDst, MemtoReg, state, trap,
                     instr_done, retired};

  localparam int C_RALU = 0, C_IALU = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_J = 5, C_JAL = 6;
  localparam int C_JR = 7, C_JALR = 8, C_ILL = 9;

  outs_t       exp_q[$];
  logic [31:0] exp_retired;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(negedge clk) begin
    outs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL cycle_st%0d @%0t: actual %h required %h", e.state, $time, act, e);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, a, e);
    end
  endtask

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h23: return C_LW;
      6'h2B: return C_SW;
      6'h04: return C_BEQ;
      6'h02: return C_J;
      6'h03: return C_JAL;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0F: return C_IALU;
      6'h00: begin
        if (fn == 6'h08) return C_JR;
        if (fn == 6'h09) return C_JALR;
        if ((fn >= 6'h20 && fn <= 6'h27) || fn == 6'h2A || fn == 6'h2B || fn == 6'h00 ||
            fn == 6'h02 || fn == 6'h03) return C_RALU;
        return C_ILL;
      end
      default: return C_ILL;
    endcase
  endfunction

  function automatic outs_t mk(input int st);
    outs_t r = '0;
    r.state = st[2:0];
    return r;
  endfunction

  // Called just after a rising edge: drive this cycle's ack, queue the expectation, advance.
  task automatic cyc(input logic ack, input outs_t r);
    r.retired = exp_retired;
    mem_ack = ack;
    exp_q.push_back(r);
    @(posedge clk);
    if (r.instr_done) exp_retired = exp_retired + 32'd1;
    #1;
  endtask

  task automatic reset_pulse(input string name);
    reset = 1'b0;
    #1;
    chk({name, "_asserted"}, {8'd0, act}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    exp_retired = 32'd0;
    #1;
    chk({name, "_state"}, {61'd0, state}, 64'd0);
    chk({name, "_memreq"}, {63'd0, mem_req}, 64'd1);
    chk({name, "_retired"}, {32'd0, retired}, 64'd0);
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input int if_lat,
                     input int mem_lat, input int trap_cycles, input bit abort_mem);
    outs_t r;
    int c;
    OpCode = op;
    Funct  = fn;
    c = classify(op, fn);
    for (int i = 0; i < if_lat; i++) begin
      r = mk(0); r.mem_req = 1; r.MemRead = 1;
      cyc(1'b0, r);
    end
    r = mk(0); r.mem_req = 1; r.MemRead = 1; r.IRWrite = 1; r.PCWrite = 1; r.ALUSrcB = 2'd1;
    cyc(1'b1, r);
    // Decode; mem_ack is held high outside memory phases to show it is ignored.
    r = mk(1); r.ALUSrcB = 2'd3;
    if (c == C_J || c == C_JAL) begin
      r.PCWrite = 1; r.PCSource = 2'd2; r.instr_done = 1;
      if (c == C_JAL) begin r.RegWrite = 1; r.RegDst = 2'd2; r.MemtoReg = 2'd2; end
    end else if (c == C_JR || c == C_JALR) begin
      r.PCWrite = 1; r.PCSource = 2'd3; r.instr_done = 1;
      if (c == C_JALR) begin r.RegWrite = 1; r.RegDst = 2'd1; r.MemtoReg = 2'd2; end
    end
    cyc(1'b1, r);
    if (c == C_ILL) begin
      for (int i = 0; i < trap_cycles; i++) begin
        r = mk(5); r.trap = 1;
        cyc(i[0], r);
      end
      return;
    end
    if (c == C_J || c == C_JAL || c == C_JR || c == C_JALR) return;
    r = mk(2); r.ALUSrcA = 1;
    case (c)
      C_LW, C_SW: r.ALUSrcB = 2'd2;
      C_BEQ: begin
        r.ALUOpSel = 2'd1; r.PCWriteCond = 1; r.PCSource = 2'd1; r.instr_done = 1;
      end
      C_RALU:  r.ALUOpSel = 2'd2;
      default: begin r.ALUSrcB = 2'd2; r.ALUOpSel = 2'd2; end
    endcase
    cyc(1'b1, r);
    if (c == C_BEQ) return;
    if (c == C_LW || c == C_SW) begin
      if (abort_mem) begin
        mem_ack = 1'b0;
        #1 chk("abort_pre_memreq", {63'd0, mem_req}, 64'd1);
        reset_pulse("abort");
        return;
      end
      for (int i = 0; i <= mem_lat; i++) begin
        r = mk(3); r.mem_req = 1; r.IorD = 1;
        r.MemRead = (c == C_LW); r.MemWrite = (c == C_SW);
        r.instr_done = (c == C_SW) && (i == mem_lat);
        cyc(i == mem_lat, r);
      end
      if (c == C_SW) return;
    end
    r = mk(4); r.RegWrite = 1; r.instr_done = 1;
    r.RegDst   = (c == C_RALU) ? 2'd1 : 2'd0;
    r.MemtoReg = (c == C_LW) ? 2'd1 : 2'd0;
    cyc(1'b1, r);
  endtask

  initial begin
    reset = 1'b0; OpCode = 6'h00; Funct = 6'h20; mem_ack = 1'b1;
    exp_retired = 32'd0;
    #2 chk("reset_outputs", {8'd0, act}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("release_state", {61'd0, state}, 64'd0);
    chk("release_memreq", {63'd0, mem_req}, 64'd1);

    run(6'h00, 6'h20, 2, 0, 0, 1'b0);          // add
    chk("add_retired", {32'd0, retired}, 64'd1);
    run(6'h23, 6'h00, 1, 0, 0, 1'b0);          // lw
    chk("lw_retired", {32'd0, retired}, 64'd2);
    run(6'h2B, 6'h11, 0, 2, 0, 1'b0);          // sw
    chk("sw_retired", {32'd0, retired}, 64'd3);
    run(6'h04, 6'h00, 0, 0, 0, 1'b0);          // beq
    run(6'h08, 6'h3F, 1, 0, 0, 1'b0);          // addi
    run(6'h0F, 6'h00, 0, 0, 0, 1'b0);          // lui
    run(6'h00, 6'h2A, 3, 0, 0, 1'b0);          // slt
    run(6'h00, 6'h08, 0, 0, 0, 1'b0);          // jr
    run(6'h00, 6'h09, 1, 0, 0, 1'b0);          // jalr
    run(6'h02, 6'h00, 0, 0, 0, 1'b0);          // j
    run(6'h00, 6'h00, 0, 0, 0, 1'b0);          // sll
    run(6'h23, 6'h00, 0, 3, 0, 1'b0);          // lw, slow memory
    chk("mix_retired", {32'd0, retired}, 64'd12);

    dut.retired_q = 32'hFFFF_FFFF;
    exp_retired   = 32'hFFFF_FFFF;
    run(6'h03, 6'h00, 0, 0, 0, 1'b0);          // jal wraps counter
    chk("jal_wrap", {32'd0, retired}, 64'd0);

    run(6'h23, 6'h00, 1, 0, 0, 1'b1);          // lw aborted mid-MEM
    run(6'h2B, 6'h00, 0, 0, 0, 1'b0);          // sw after abort
    chk("post_abort_retired", {32'd0, retired}, 64'd1);

    run(6'h3F, 6'h00, 0, 0, 100, 1'b0);        // illegal opcode
    chk("trap_state", {61'd0, state}, 64'd5);
    chk("trap_flag", {63'd0, trap}, 64'd1);
    reset_pulse("trap_exit");

    run(6'h00, 6'h05, 0, 0, 3, 1'b0);          // illegal R-type funct
    chk("trap2_flag", {63'd0, trap}, 64'd1);
    reset_pulse("trap2_exit");
    run(6'h0C, 6'h00, 0, 0, 0, 1'b0);          // andi

    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
